// File: rtl/ac97_frame_timer.sv
// AC97 output-frame timing generator: 256-bit-clock frames with SYNC, serializer load and slot latch enables.
// A phase accumulator marks frames valid so lower sample rates ride on a fixed-rate link.
module ac97_frame_timer #(
  parameter int NUM_SLOTS = 5,
  parameter int SYNC_LEN  = 16,
  parameter int BASE_HZ   = 48000,
  parameter int RATE_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [RATE_W-1:0]    rate_hz,
  input  logic                 sample_rdy,
  input  logic                 clr_underrun,
  output logic                 sync,
  output logic                 ld,
  output logic [NUM_SLOTS-1:0] out_le,
  output logic                 slot_valid,
  output logic                 sample_req,
  output logic                 underrun,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_e;

  localparam logic [RATE_W:0] BASE_W = (RATE_W+1)'(BASE_HZ);
  localparam logic [7:0]      SYNC_W = 8'(SYNC_LEN);
  localparam logic [7:0]      LAST   = 8'hFF;

  state_e                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [RATE_W-1:0]     acc_q, acc_d;
  logic                  sv_q, sv_d;
  logic                  req_q, req_d;
  logic                  ur_q, ur_d;
  logic                  sync_q, sync_d;
  logic                  ld_q, ld_d;
  logic [NUM_SLOTS-1:0]  le_q, le_d;

  logic                  boundary, from_idle, stop_done, due, live;
  logic [RATE_W:0]       rate_clip, sum, diff;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    boundary  = 1'b0;
    from_idle = 1'b0;
    stop_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d   = RUN;
          cnt_d     = 8'h00;
          boundary  = 1'b1;
          from_idle = 1'b1;
        end
      end
      RUN: begin
        cnt_d    = cnt_q + 8'd1;
        boundary = (cnt_q == LAST);
        if (!en) state_d = STOP;
      end
      STOP: begin
        cnt_d = cnt_q + 8'd1;
        if (en) begin
          state_d = RUN;
        end else if (cnt_q == LAST) begin
          state_d   = IDLE;
          cnt_d     = LAST;
          stop_done = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = LAST;
      end
    endcase
  end

  // Rate accounting happens once per frame; a fresh start discards any residue in acc.
  always_comb begin
    rate_clip = ({1'b0, rate_hz} > BASE_W) ? BASE_W : {1'b0, rate_hz};
    sum       = (from_idle ? '0 : {1'b0, acc_q}) + rate_clip;
    due       = boundary && (sum >= BASE_W);
    diff      = due ? (sum - BASE_W) : sum;
    acc_d     = boundary ? diff[RATE_W-1:0] : acc_q;

    sv_d = sv_q;
    if (boundary)       sv_d = due && sample_rdy;
    else if (stop_done) sv_d = 1'b0;

    req_d = due && sample_rdy;

    ur_d = ur_q;
    if (due && !sample_rdy) ur_d = 1'b1;
    else if (clr_underrun)  ur_d = 1'b0;

    live   = (state_q != IDLE);
    ld_d   = live && (cnt_q == 8'h00);
    sync_d = live && (cnt_q < SYNC_W);
    for (int i = 0; i < NUM_SLOTS; i++) begin
      le_d[i] = live && (cnt_q == 8'(17 + 20 * i));
    end
  end

  // NOTE: state uses non-blocking assignments, and the reset is sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= LAST;
      acc_q   <= '0;
      sv_q    <= 1'b0;
      req_q   <= 1'b0;
      ur_q    <= 1'b0;
      sync_q  <= 1'b0;
      ld_q    <= 1'b0;
      le_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sv_q    <= sv_d;
      req_q   <= req_d;
      ur_q    <= ur_d;
      sync_q  <= sync_d;
      ld_q    <= ld_d;
      le_q    <= le_d;
    end
  end

  assign sync       = sync_q;
  assign ld         = ld_q;
  assign out_le     = le_q;
  assign slot_valid = sv_q;
  assign sample_req = req_q;
  assign underrun   = ur_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ac97_frame_timer.sv
// Self-checking bench for ac97_frame_timer: a frame-level arithmetic model checked every cycle,
// plus literal expectations for frame timing, valid-frame ratios, underrun, stop and reset.
module tb_ac97_frame_timer;
  localparam int NS   = 5;
  localparam int SYNC = 16;
  localparam int BASE = 48000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic [15:0]   rate_hz = '0;
  logic          sample_rdy = 1'b0;
  logic          clr_underrun = 1'b0;
  logic          sync, ld, slot_valid, sample_req, underrun, busy;
  logic [NS-1:0] out_le;

  ac97_frame_timer #(.NUM_SLOTS(NS), .SYNC_LEN(SYNC), .BASE_HZ(BASE), .RATE_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .rate_hz(rate_hz), .sample_rdy(sample_rdy),
    .clr_underrun(clr_underrun), .sync(sync), .ld(ld), .out_le(out_le),
    .slot_valid(slot_valid), .sample_req(sample_req), .underrun(underrun), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got=%0h expected=%0h", name, $time, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out at t=%0t", name, $time);
  endtask

  // Model: link position in the frame, run mode (0 idle, 1 run, 2 stopping) and phase residue.
  int            m_mode = 0;
  int            m_cnt = 255;
  int            m_acc = 0;
  int            m_r, m_a;
  bit            m_live, m_fs, m_due;
  bit            e_sv = 0, e_req = 0, e_ur = 0, e_ld = 0, e_sync = 0;
  logic [NS-1:0] e_le = '0;

  always @(posedge clk) begin
    if (!rst) begin
      m_mode = 0; m_cnt = 255; m_acc = 0;
      e_sv = 0; e_req = 0; e_ur = 0; e_ld = 0; e_sync = 0; e_le = '0;
    end else begin
      m_live = (m_mode != 0);
      e_ld   = m_live && (m_cnt == 0);
      e_sync = m_live && (m_cnt < SYNC);
      for (int i = 0; i < NS; i++) e_le[i] = m_live && (m_cnt == 17 + 20 * i);
      m_fs  = (m_mode == 0 && en) || (m_mode == 1 && m_cnt == 255);
      e_req = 0;
      if (m_fs) begin
        m_r   = (int'(rate_hz) > BASE) ? BASE : int'(rate_hz);
        m_a   = ((m_mode == 0) ? 0 : m_acc) + m_r;
        m_due = (m_a >= BASE);
        m_acc = m_due ? m_a - BASE : m_a;
        e_sv  = m_due && sample_rdy;
        e_req = e_sv;
        if (m_due && !sample_rdy) e_ur = 1;
        else if (clr_underrun)    e_ur = 0;
      end else if (clr_underrun) begin
        e_ur = 0;
      end
      case (m_mode)
        0: if (en) begin m_mode = 1; m_cnt = 0; end
        1: begin m_cnt = (m_cnt + 1) % 256; if (!en) m_mode = 2; end
        default: begin
          if (en) begin
            m_mode = 1; m_cnt = (m_cnt + 1) % 256;
          end else if (m_cnt == 255) begin
            m_mode = 0; e_sv = 0;
          end else begin
            m_cnt = m_cnt + 1;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (checking)
      check("cycle_outputs", {sync, ld, out_le, slot_valid, sample_req, underrun, busy},
            {e_sync, e_ld, e_le, e_sv, e_req, e_ur, (m_mode != 0)});
  end

  function automatic logic [NS+5:0] all_outs();
    return {sync, ld, out_le, slot_valid, sample_req, underrun, busy};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    en = 1'b0; clr_underrun = 1'b0;
    rst = 1'b0;
    cyc(2);
    check("reset_outputs", all_outs(), '0);
    rst = 1'b1;
    cyc(1);
  endtask

  // Returns at the negedge where the link counter holds v, so inputs set now act on that count.
  task automatic wait_pos(input int v);
    bit hit = 0;
    for (int i = 0; i < 600 && !hit; i++) begin
      @(negedge clk);
      if (m_cnt == v) hit = 1;
    end
    if (!hit) timeout("wait_pos");
  endtask

  task automatic count_frames(input int n, output int nv, output int nr);
    int nld = 0;
    nv = 0; nr = 0;
    for (int i = 0; i < n * 256 + 600 && nld < n; i++) begin
      @(negedge clk);
      if (sample_req) nr++;
      if (ld) begin
        nld++;
        if (slot_valid) nv++;
      end
    end
    if (nld < n) timeout("count_frames");
  endtask

  task automatic frame_probe();
    bit got_ld = 0;
    int gap = -1;
    int nsync = 0;
    int le_at [NS];
    for (int i = 0; i < NS; i++) le_at[i] = -1;
    for (int i = 0; i < 300 && !got_ld; i++) begin
      @(negedge clk);
      if (ld) got_ld = 1;
    end
    if (!got_ld) begin
      timeout("probe_ld");
      return;
    end
    for (int t = 0; t < 300 && gap < 0; t++) begin
      if (t > 0 && ld) gap = t;
      else begin
        if (sync) nsync++;
        for (int i = 0; i < NS; i++) if (out_le[i]) le_at[i] = t;
        @(negedge clk);
      end
    end
    check("ld_period", 64'(gap), 64'd256);
    check("sync_len", 64'(nsync), 64'd16);
    for (int i = 0; i < NS; i++) check($sformatf("le%0d_offset", i), 64'(le_at[i]), 64'(17 + 20 * i));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv, nr, k;
    bit stayed;
    logic [2:0] pat;

    do_reset();
    checking = 1'b1;

    // Full rate: every frame valid, plus frame timing.
    rate_hz = 16'd48000; sample_rdy = 1'b1; en = 1'b1;
    count_frames(8, nv, nr);
    check("full_rate_valid", 64'(nv), 64'd8);
    check("full_rate_req", 64'(nr), 64'd8);
    frame_probe();

    // 8 kHz: one frame in six.
    do_reset();
    rate_hz = 16'd8000; en = 1'b1;
    count_frames(60, nv, nr);
    check("r8000_valid", 64'(nv), 64'd10);
    check("r8000_req", 64'(nr), 64'd10);

    // 44.1 kHz over 40 frames: floor(40*44100/48000) = 36.
    do_reset();
    rate_hz = 16'hAC44; en = 1'b1;
    count_frames(40, nv, nr);
    check("r44100_valid", 64'(nv), 64'd36);

    // Rates above the link rate clamp.
    do_reset();
    rate_hz = 16'hFFFF; en = 1'b1;
    count_frames(10, nv, nr);
    check("r65535_valid", 64'(nv), 64'd10);

    // Underrun: one frame's sample missing.
    do_reset();
    rate_hz = 16'd48000; sample_rdy = 1'b1; en = 1'b1;
    count_frames(2, nv, nr);
    wait_pos(8'h80);
    sample_rdy = 1'b0;
    wait_pos(8'h80);
    check("underrun_set", 64'(underrun), 64'd1);
    check("underrun_frame_invalid", 64'(slot_valid), 64'd0);
    sample_rdy = 1'b1;
    count_frames(1, nv, nr);
    check("after_underrun_valid", 64'(nv), 64'd1);
    check("underrun_held", 64'(underrun), 64'd1);
    wait_pos(255);
    sample_rdy = 1'b0; clr_underrun = 1'b1;
    @(negedge clk);
    sample_rdy = 1'b1; clr_underrun = 1'b0;
    check("underrun_set_wins", 64'(underrun), 64'd1);
    cyc(3);
    clr_underrun = 1'b1;
    @(negedge clk);
    clr_underrun = 1'b0;
    check("underrun_cleared", 64'(underrun), 64'd0);

    // Graceful stop from cnt 0x40: 192 clocks until idle.
    wait_pos(8'h40);
    en = 1'b0;
    k = 0;
    for (int i = 0; i < 400 && busy; i++) begin
      @(negedge clk);
      k++;
    end
    check("stop_cycles", 64'(k), 64'd192);
    cyc(3);
    check("idle_outputs", all_outs(), '0);

    // Re-raise during stop: frames continue without a gap.
    en = 1'b1;
    count_frames(1, nv, nr);
    wait_pos(8'h40);
    en = 1'b0;
    wait_pos(8'h80);
    en = 1'b1;
    k = 0; stayed = 1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      k++;
      if (!busy) stayed = 0;
      if (ld) break;
    end
    check("rerun_next_ld", 64'(k), 64'd129);
    check("rerun_busy_held", 64'(stayed), 64'd1);

    // Reset mid-frame, then the 22.05 kHz pattern restarts from zero residue.
    rate_hz = 16'd22050;
    count_frames(2, nv, nr);
    wait_pos(8'h30);
    rst = 1'b0;
    @(negedge clk);
    check("midframe_reset_outputs", all_outs(), '0);
    rst = 1'b1; en = 1'b0;
    cyc(2);
    en = 1'b1;
    for (int f = 0; f < 3; f++) begin
      count_frames(1, nv, nr);
      pat[f] = (nv == 1);
    end
    check("r22050_restart_pattern", 64'(pat), 64'b100);

    // Random traffic against the model.
    for (int c = 0; c < 100; c++) begin
      case ($urandom_range(0, 6))
        0: rate_hz = 16'd0;
        1: rate_hz = 16'd8000;
        2: rate_hz = 16'd11025;
        3: rate_hz = 16'd22050;
        4: rate_hz = 16'hAC44;
        5: rate_hz = 16'd48000;
        default: rate_hz = 16'($urandom);
      endcase
      sample_rdy = ($urandom_range(0, 3) != 0);
      en = ($urandom_range(0, 5) != 0);
      clr_underrun = ($urandom_range(0, 7) == 0);
      @(negedge clk);
      clr_underrun = 1'b0;
      cyc($urandom_range(20, 100));
    end

    checking = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
